mux4: RTL and testbench
=======================

# mux4

Single-bit 4:1 multiplexer with a combinational output and a registered copy of that output. It selects one of four data bits using two select lines, `j0` as the MSB and `j1` as the LSB. It is a leaf datapath primitive for building wider selectors and sample-and-hold paths. The combinational path has no dependence on clock or reset; the registered path is synchronous to `clk` with asynchronous clearing.

## Interface
- No parameters.
- Clocking: one clock; reset is asynchronous and active-high.
- `clk`  input  1  rising-edge clock for all registered outputs.
- `rst`  input  1  asynchronous, active-high reset; clears all registers.
- `i`  input  4, declared `[0:3]`  data inputs; `i[0]` is the leftmost/MSB bit of a literal.
- `j0`  input  1  select MSB.
- `j1`  input  1  select LSB.
- `o`  output  1  combinational selected bit.
- `o_q`  output  1  registered copy of `o`.
- `sel_q`  output  2  registered select `{j0,j1}`.
- `chg`  output  1  one-cycle flag: registered output changed at the last edge.

## Operation
- Select index: idx = {j0, j1}, an unsigned value 0..3.
- idx 0 (j0=0, j1=0): o = i[0].
- idx 1 (j0=0, j1=1): o = i[1].
- idx 2 (j0=1, j1=0): o = i[2].
- idx 3 (j0=1, j1=1): o = i[3].
- Literal mapping: `i = 4'b1000` sets i[0]=1. `4'b0001` sets i[3]=1.
- Non-selected bits have no effect on `o`.
- If any select bit is X/Z, `o` is X in simulation. No default lane is substituted.
- `o` is purely combinational and is unaffected by `rst` and `clk`.
- On each rising edge of `clk` with `rst` low:
  - o_q <= o
  - sel_q <= {j0,j1}
  - chg <= (o != o_q), comparing the current combinational value against the pre-edge registered value.

## Timing
- `o`: zero-cycle latency, combinational from `i`, `j0`, `j1`.
- `o_q`, `sel_q`: one-cycle latency. Values sampled at rising edge N are visible after edge N.
- `chg`:
  - High for exactly the cycle following an edge at which `o_q` toggled.
  - Low otherwise.
  - Sustained toggling keeps it high on consecutive cycles.
- Reset:
  - Assertion of `rst` immediately clears o_q=0, sel_q=2'b00 and chg=0, without waiting for a clock edge.
  - While `rst` is high, registers hold these values regardless of clock edges.
  - `o` keeps tracking inputs during reset.
- Reset release: the first rising edge with `rst` low captures normally. chg = (o != 0) at that edge.
- Reset asserted mid-cycle between edges: outputs clear at once. No pending capture is retained.
- Input changes between edges affect only `o`. Registers reflect the value present at the edge.

## Test plan
- Each select with all data zero (i=0000, {j0,j1} = 00, 01, 10, 11): o=0 for every select.
- One-hot walk, combinational:
  - i=1000, j0=0, j1=0 -> o=1
  - i=0100, j0=0, j1=1 -> o=1
  - i=0010, j0=1, j1=0 -> o=1
  - i=0001, j0=1, j1=1 -> o=1
- Lane isolation: i=0111 with sel 00 -> o=0; i=1110 with sel 11 -> o=0.
- Registered path:
  - Release reset, set i=1000 and sel 00, then clock.
  - After the edge: o_q=1, sel_q=00, chg=1.
  - Next edge with no change: chg=0.
  - Then i=0000: o drops immediately, and after the next edge o_q=0, chg=1.
- Async reset: with o_q=1 and sel_q=11, assert `rst` between edges.
  - o_q=0, sel_q=00, chg=0 immediately, before any edge.
  - `o` still follows the inputs.
- Random: 200 cycles of random i/j0/j1. Check:
  - o == i[{j0,j1}] at every change.
  - o_q and sel_q match the values sampled on the prior edge.
  - chg matches the o_q toggle.

Source files
------------

// File: rtl/mux4.sv
// Single-bit 4:1 selector with a combinational output plus a registered
// sample of that output, the captured select and a one-cycle change flag.
module mux4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:3] i,
    input  logic       j0,
    input  logic       j1,
    output logic       o,
    output logic       o_q,
    output logic [1:0] sel_q,
    output logic       chg
);

    logic [1:0] idx;

    assign idx = {j0, j1};

    // i is declared [0:3], so idx 0 picks the leftmost literal bit; an X select
    // propagates to o in simulation rather than falling back to a lane.
    assign o = i[idx];

    // chg compares the live output against the pre-edge registered value, so it
    // marks exactly the edges where o_q toggles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q   <= 1'b0;
            sel_q <= 2'b00;
            chg   <= 1'b0;
        end else begin
            o_q   <= o;
            sel_q <= idx;
            chg   <= o ^ o_q;
        end
    end

endmodule

// File: tb/tb_mux4.sv
// Self-checking bench for mux4: directed steps followed by randomized cycles,
// all compared against an arithmetic reference model.
module tb_mux4;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:3] i;
    logic       j0;
    logic       j1;
    logic       o;
    logic       o_q;
    logic [1:0] sel_q;
    logic       chg;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    logic       exp_oq;
    logic [1:0] exp_sel;
    logic       exp_chg;

    always #5 clk = ~clk;

    mux4 dut (
        .clk   (clk),
        .rst   (rst),
        .i     (i),
        .j0    (j0),
        .j1    (j1),
        .o     (o),
        .o_q   (o_q),
        .sel_q (sel_q),
        .chg   (chg)
    );

    // Literal value data written as 4'bABCD: select s picks the s-th digit from the left.
    function automatic logic ref_o(input logic [3:0] data, input int sel);
        int weight;
        weight = 1 << (3 - sel);
        return ((int'(data) / weight) % 2) == 1;
    endfunction

    task automatic check_output(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] data, input logic s0, input logic s1);
        i  = data;
        j0 = s0;
        j1 = s1;
    endtask

    function automatic logic model_o();
        logic [3:0] data;
        data = i;
        return ref_o(data, int'({j0, j1}));
    endfunction

    // Advance one clock edge and update the expected register state from the
    // inputs that were stable just before the edge.
    task automatic clock_edge();
        logic       pre_o;
        logic [1:0] pre_sel;
        pre_o   = model_o();
        pre_sel = {j0, j1};
        @(posedge clk);
        if (!rst) begin
            exp_chg = (pre_o != exp_oq);
            exp_oq  = pre_o;
            exp_sel = pre_sel;
        end else begin
            exp_chg = 1'b0;
            exp_oq  = 1'b0;
            exp_sel = 2'b00;
        end
        #1;
    endtask

    task automatic check_regs(input string tag);
        check_output({tag, "_o_q"}, {1'b0, o_q}, {1'b0, exp_oq});
        check_output({tag, "_sel_q"}, sel_q, exp_sel);
        check_output({tag, "_chg"}, {1'b0, chg}, {1'b0, exp_chg});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] one_hot [4];
        one_hot[0] = 4'b1000;
        one_hot[1] = 4'b0100;
        one_hot[2] = 4'b0010;
        one_hot[3] = 4'b0001;

        exp_oq  = 1'b0;
        exp_sel = 2'b00;
        exp_chg = 1'b0;
        rst = 1'b1;
        apply_stimulus(4'b0000, 1'b0, 1'b0);
        clock_edge();
        clock_edge();
        check_regs("reset");

        // Combinational checks while held in reset: o must still track inputs.
        for (int s = 0; s < 4; s++) begin
            apply_stimulus(4'b0000, s[1], s[0]);
            #1;
            check_output("zero_data", {1'b0, o}, 2'b00);
        end
        for (int s = 0; s < 4; s++) begin
            apply_stimulus(one_hot[s], s[1], s[0]);
            #1;
            check_output("one_hot", {1'b0, o}, 2'b01);
        end
        apply_stimulus(4'b0111, 1'b0, 1'b0);
        #1;
        check_output("isolate_sel0", {1'b0, o}, 2'b00);
        apply_stimulus(4'b1110, 1'b1, 1'b1);
        #1;
        check_output("isolate_sel3", {1'b0, o}, 2'b00);
        check_regs("reset_hold");

        // Registered path after reset release.
        rst = 1'b0;
        apply_stimulus(4'b1000, 1'b0, 1'b0);
        clock_edge();
        check_regs("first_capture");
        check_output("first_capture_lit", {o_q, chg}, 2'b11);
        clock_edge();
        check_regs("steady");
        check_output("steady_chg_lit", {1'b0, chg}, 2'b00);
        apply_stimulus(4'b0000, 1'b0, 1'b0);
        #1;
        check_output("drop_comb", {1'b0, o}, 2'b00);
        check_output("drop_reg_holds", {1'b0, o_q}, 2'b01);
        clock_edge();
        check_regs("drop_edge");
        check_output("drop_edge_lit", {o_q, chg}, 2'b01);
        apply_stimulus(4'b0001, 1'b1, 1'b1);
        clock_edge();
        check_regs("sel3_capture");
        check_output("sel3_lit", sel_q, 2'b11);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        exp_oq  = 1'b0;
        exp_sel = 2'b00;
        exp_chg = 1'b0;
        #1;
        check_regs("async_reset");
        check_output("async_o_tracks", {1'b0, o}, 2'b01);
        apply_stimulus(4'b1110, 1'b1, 1'b1);
        #1;
        check_output("async_o_follows", {1'b0, o}, 2'b00);
        clock_edge();
        check_regs("reset_edge");
        rst = 1'b0;

        // Randomized cycles with a mid-cycle input change that must not be captured.
        for (int n = 0; n < 200; n++) begin
            apply_stimulus(4'($urandom), 1'($urandom), 1'($urandom));
            #1;
            check_output("rand_o_a", {1'b0, o}, {1'b0, model_o()});
            apply_stimulus(4'($urandom), 1'($urandom), 1'($urandom));
            #1;
            check_output("rand_o_b", {1'b0, o}, {1'b0, model_o()});
            clock_edge();
            check_regs("rand");
        end

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
